// File: rtl/ddc_ctrl_pkg.sv
// ddc_ctrl_pkg
//   Shared definitions for the DDC acquisition controller: FSM state
//   encoding, default parameter values and a small state-class helper.
package ddc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_RATE_WIDTH   = 7;
  localparam int DEF_CIC_MAXRATE  = 64;
  localparam int DEF_FLUSH_CYCLES = 4;
  localparam int DEF_SETTLE_OUTS  = 5;

  // States in which the DDC is producing (possibly unsettled) samples and
  // ADC activity is passed through to it.
  function automatic logic is_active(state_e s);
    return (s == ST_SETTLE) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/ddc_ctrl_outreg.sv
// ddc_ctrl_outreg
//   One-entry output register with valid/ready handshake and overflow flag.
//   Ports:
//     clk_i, rst_i  : clock, asynchronous active-high reset
//     clear_i       : drop any held entry (controller leaving the run phase)
//     ovf_clr_i     : clear the sticky overflow flag
//     load_i        : new sample offered, data_i carries it
//     ready_i       : downstream accepts the held entry this clock
//     valid_o       : entry held, data_o carries it
//     overflow_o    : sticky, a sample arrived while the entry was stalled
//
//   Handshake: an entry transfers on any clock where valid_o && ready_i.
//   data_o never changes while valid_o && !ready_i. A load on the same clock
//   as a transfer replaces the entry; a load while stalled is dropped.
module ddc_ctrl_outreg
  import ddc_ctrl_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         ovf_clr_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         overflow_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         ovf_q, ovf_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i && (!valid_q || ready_i)) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (load_i) begin
      ovf_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
    if (ovf_clr_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/ddc_ctrl.sv
// ddc_ctrl
//   Acquisition controller for a digital down-converter (DDC) with a CIC
//   decimator. Sequences IDLE -> FLUSH (DDC held in reset) -> SETTLE (first
//   CIC outputs discarded) -> RUN (results forwarded to a one-entry output
//   register). Generates the DDC activity strobes and decimation marker.
//   Ports:
//     clk_i, rst_i                 : clock, asynchronous active-high reset
//     start_i, stop_i              : acquisition control pulses
//     rate_i, rate_we_i            : decimation rate and its write strobe
//     adc_valid_i                  : one strobe per ADC sample
//     ddc_en_o, ddc_rst_o          : DDC enable / synchronous reset
//     act_o, act_out_o             : DDC sample strobe / decimated-output strobe
//     ddc_val_i, ddc_amp_i,
//     ddc_phase_i                  : DDC result stream
//     out_valid_o, out_amp_o,
//     out_phase_o, out_ready_i     : output stream (valid/ready)
//     busy_o, overflow_o, cfg_err_o: status
//     dbg_state_o                  : current FSM state
module ddc_ctrl
  import ddc_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int RATE_WIDTH   = DEF_RATE_WIDTH,
  parameter int CIC_MAXRATE  = DEF_CIC_MAXRATE,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int SETTLE_OUTS  = DEF_SETTLE_OUTS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [RATE_WIDTH-1:0] rate_i,
  input  logic                  rate_we_i,
  input  logic                  adc_valid_i,
  output logic                  ddc_en_o,
  output logic                  ddc_rst_o,
  output logic                  act_o,
  output logic                  act_out_o,
  input  logic                  ddc_val_i,
  input  logic [DATA_WIDTH-1:0] ddc_amp_i,
  input  logic [DATA_WIDTH:0]   ddc_phase_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_amp_o,
  output logic [DATA_WIDTH:0]   out_phase_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  overflow_o,
  output logic                  cfg_err_o,
  output state_e                dbg_state_o
);

  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int SCW = (SETTLE_OUTS > 0) ? $clog2(SETTLE_OUTS + 1) : 1;
  localparam int OW  = 2 * DATA_WIDTH + 1;

  // Flush counter counts down to zero, so it is loaded with one less than
  // the number of FLUSH clocks.
  localparam logic [FCW-1:0]        FLUSH_LOAD  = FCW'(FLUSH_CYCLES - 1);
  localparam logic [FCW-1:0]        FLUSH_ONE   = FCW'(1);
  localparam logic [SCW-1:0]        SETTLE_LOAD = SCW'(SETTLE_OUTS);
  localparam logic [SCW-1:0]        SETTLE_ONE  = SCW'(1);
  localparam logic [RATE_WIDTH:0]   MAX_RATE    = (RATE_WIDTH + 1)'(CIC_MAXRATE);
  localparam logic [RATE_WIDTH-1:0] RATE_ONE    = RATE_WIDTH'(1);

  state_e                state_q, state_d;
  logic [FCW-1:0]        flush_cnt_q, flush_cnt_d;
  logic [SCW-1:0]        settle_cnt_q, settle_cnt_d;
  logic [RATE_WIDTH-1:0] rate_q, rate_d;
  logic [RATE_WIDTH-1:0] dec_cnt_q, dec_cnt_d;
  logic                  act_q, act_d;
  logic                  act_out_q, act_out_d;
  logic                  cfg_err_q, cfg_err_d;

  logic                  stop_win;
  logic                  rate_ok;
  logic                  rate_wr;
  logic                  rate_apply;
  logic [RATE_WIDTH-1:0] dec_base;
  logic                  dec_last;

  // Stop overrides everything else in a busy state, including a rate write.
  assign stop_win   = stop_i && (state_q != ST_IDLE);
  assign rate_ok    = (rate_i != '0) && ({1'b0, rate_i} <= MAX_RATE);
  assign rate_wr    = rate_we_i && !stop_win;
  assign rate_apply = rate_wr && rate_ok;

  // The decimation phase only survives while the DDC keeps running; any
  // flush or idle period restarts it from zero.
  assign dec_base = is_active(state_q) ? dec_cnt_q : '0;
  assign dec_last = (dec_base == rate_q - RATE_ONE);

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    settle_cnt_d = settle_cnt_q;
    rate_d       = rate_apply ? rate_i : rate_q;
    cfg_err_d    = rate_wr && !rate_ok;

    if (stop_win) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == '0) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = SETTLE_LOAD;
          end else begin
            flush_cnt_d = flush_cnt_q - FLUSH_ONE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == '0) begin
            state_d = ST_RUN;
          end else if (ddc_val_i) begin
            settle_cnt_d = settle_cnt_q - SETTLE_ONE;
            if (settle_cnt_q == SETTLE_ONE) state_d = ST_RUN;
          end
        end
        default: ;
      endcase
      // A new rate invalidates the CIC contents, so a running DDC restarts.
      if (rate_apply && is_active(state_q)) begin
        state_d     = ST_FLUSH;
        flush_cnt_d = FLUSH_LOAD;
      end
    end

    // act_o is only ever high while the registered state is SETTLE/RUN.
    act_d     = adc_valid_i && is_active(state_d);
    act_out_d = act_d && dec_last;
    dec_cnt_d = act_d ? (dec_last ? '0 : dec_base + RATE_ONE) : dec_base;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      flush_cnt_q  <= '0;
      settle_cnt_q <= '0;
      rate_q       <= RATE_ONE;
      dec_cnt_q    <= '0;
      act_q        <= 1'b0;
      act_out_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      rate_q       <= rate_d;
      dec_cnt_q    <= dec_cnt_d;
      act_q        <= act_d;
      act_out_q    <= act_out_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  logic          out_clear;
  logic          out_load;
  logic          ovf_clr;
  logic [OW-1:0] out_data;

  assign out_clear = (state_d == ST_IDLE) || (state_d == ST_FLUSH);
  assign out_load  = (state_q == ST_RUN) && ddc_val_i;
  assign ovf_clr   = start_i && (state_q == ST_IDLE);

  ddc_ctrl_outreg #(.W(OW)) u_outreg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (out_clear),
    .ovf_clr_i  (ovf_clr),
    .load_i     (out_load),
    .data_i     ({ddc_amp_i, ddc_phase_i}),
    .ready_i    (out_ready_i),
    .valid_o    (out_valid_o),
    .data_o     (out_data),
    .overflow_o (overflow_o)
  );

  assign {out_amp_o, out_phase_o} = out_data;

  assign ddc_en_o    = (state_q != ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign ddc_rst_o   = (state_q == ST_FLUSH);
  assign act_o       = act_q;
  assign act_out_o   = act_out_q;
  assign cfg_err_o   = cfg_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ddc_ctrl.sv
// tb_ddc_ctrl
//   Directed bench for ddc_ctrl: a cycle table for start/flush/settle/output,
//   then hand-written sequences for decimation spacing, backpressure,
//   rate writes, stop/start collision and asynchronous reset.
module tb_ddc_ctrl;
  import ddc_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start, stop, rate_we, adc_valid, ddc_val, ready;
  logic [6:0]  rate;
  logic [15:0] amp;
  logic [16:0] phase;
  logic        ddc_en, ddc_rst, act, act_out, out_valid, busy, overflow, cfg_err;
  logic [15:0] out_amp;
  logic [16:0] out_phase;
  state_e      dbg_state;

  ddc_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .stop_i      (stop),
    .rate_i      (rate),
    .rate_we_i   (rate_we),
    .adc_valid_i (adc_valid),
    .ddc_en_o    (ddc_en),
    .ddc_rst_o   (ddc_rst),
    .act_o       (act),
    .act_out_o   (act_out),
    .ddc_val_i   (ddc_val),
    .ddc_amp_i   (amp),
    .ddc_phase_i (phase),
    .out_valid_o (out_valid),
    .out_amp_o   (out_amp),
    .out_phase_o (out_phase),
    .out_ready_i (ready),
    .busy_o      (busy),
    .overflow_o  (overflow),
    .cfg_err_o   (cfg_err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; rate_we = 0; rate = '0;
    adc_valid = 0; ddc_val = 0; ready = 1; amp = '0; phase = '0;
  endtask

  // n ADC strobes separated by gaps; act_out expected on every rate-th one.
  task automatic act_burst(input string tag, input int n, input int r);
    for (int k = 0; k < n; k++) begin
      adc_valid = 1;
      tick();
      chk({tag, "_act"}, 32'(act), 32'd1);
      chk({tag, "_act_out"}, 32'(act_out), 32'((k % r) == (r - 1)));
      adc_valid = 0;
      tick();
      chk({tag, "_act_gap"}, 32'(act | act_out), 32'd0);
    end
  endtask

  task automatic settle_drop(input string tag);
    for (int k = 0; k < 5; k++) begin
      ddc_val = 1; amp = 16'h0BAD;
      tick();
      chk({tag, "_settle_valid"}, 32'(out_valid), 32'd0);
    end
    ddc_val = 0;
    chk({tag, "_run"}, 32'(dbg_state), 32'(ST_RUN));
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic        st, sp, we;
    logic [6:0]  rt;
    logic        dv, rdy;
    logic [15:0] a;
    logic [16:0] p;
    state_e      es;
    logic        er, ev;
    logic [15:0] ea;
    logic [16:0] ep;
    logic        ec;
  } vec_t;

  function automatic vec_t mk(logic st, logic sp, logic we, logic [6:0] rt, logic dv, logic rdy,
                              logic [15:0] a, logic [16:0] p, state_e es, logic er, logic ev,
                              logic [15:0] ea, logic [16:0] ep, logic ec);
    vec_t v;
    v.st = st; v.sp = sp; v.we = we; v.rt = rt; v.dv = dv; v.rdy = rdy; v.a = a; v.p = p;
    v.es = es; v.er = er; v.ev = ev; v.ea = ea; v.ep = ep; v.ec = ec;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    idle_inputs();

    // reset state, checked while reset is still asserted
    #12;
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_outs", 32'({ddc_en, ddc_rst, act, act_out, out_valid, busy, overflow, cfg_err}), 32'd0);
    chk("rst_data", 32'({out_amp, out_phase}), 32'd0);
    @(negedge clk);
    rst = 0;

    //                st sp we rt  dv rdy amp       phase      state      rst vld e_amp     e_phase    cfg
    tbl[0]  = mk(0, 0, 1, 4,  0, 1, 16'h0,    17'h0,     ST_IDLE,   0, 0, 16'h0,    17'h0,     0);
    tbl[1]  = mk(0, 0, 1, 0,  0, 1, 16'h0,    17'h0,     ST_IDLE,   0, 0, 16'h0,    17'h0,     1);
    tbl[2]  = mk(1, 0, 0, 0,  0, 1, 16'h0,    17'h0,     ST_FLUSH,  1, 0, 16'h0,    17'h0,     0);
    tbl[3]  = mk(0, 0, 0, 0,  0, 1, 16'h0,    17'h0,     ST_FLUSH,  1, 0, 16'h0,    17'h0,     0);
    tbl[4]  = mk(0, 0, 0, 0,  0, 1, 16'h0,    17'h0,     ST_FLUSH,  1, 0, 16'h0,    17'h0,     0);
    tbl[5]  = mk(0, 0, 0, 0,  0, 1, 16'h0,    17'h0,     ST_FLUSH,  1, 0, 16'h0,    17'h0,     0);
    tbl[6]  = mk(0, 0, 0, 0,  0, 1, 16'h0,    17'h0,     ST_SETTLE, 0, 0, 16'h0,    17'h0,     0);
    tbl[7]  = mk(0, 0, 0, 0,  1, 1, 16'h0BAD, 17'h1,     ST_SETTLE, 0, 0, 16'h0,    17'h0,     0);
    tbl[8]  = mk(0, 0, 0, 0,  1, 1, 16'h0BAD, 17'h2,     ST_SETTLE, 0, 0, 16'h0,    17'h0,     0);
    tbl[9]  = mk(0, 0, 0, 0,  1, 1, 16'h0BAD, 17'h3,     ST_SETTLE, 0, 0, 16'h0,    17'h0,     0);
    tbl[10] = mk(0, 0, 0, 0,  1, 1, 16'h0BAD, 17'h4,     ST_SETTLE, 0, 0, 16'h0,    17'h0,     0);
    tbl[11] = mk(0, 0, 0, 0,  1, 1, 16'h0BAD, 17'h5,     ST_RUN,    0, 0, 16'h0,    17'h0,     0);
    tbl[12] = mk(0, 0, 0, 0,  1, 1, 16'h1234, 17'h1ABCD, ST_RUN,    0, 1, 16'h1234, 17'h1ABCD, 0);
    tbl[13] = mk(0, 0, 0, 0,  1, 1, 16'h8001, 17'h00042, ST_RUN,    0, 1, 16'h8001, 17'h00042, 0);
    tbl[14] = mk(0, 0, 0, 0,  0, 1, 16'h0,    17'h0,     ST_RUN,    0, 0, 16'h0,    17'h0,     0);
    tbl[15] = mk(0, 0, 0, 0,  1, 0, 16'hBEEF, 17'h10000, ST_RUN,    0, 1, 16'hBEEF, 17'h10000, 0);
    tbl[16] = mk(0, 0, 0, 0,  0, 0, 16'h5555, 17'h05555, ST_RUN,    0, 1, 16'hBEEF, 17'h10000, 0);
    tbl[17] = mk(0, 0, 0, 0,  0, 1, 16'h0,    17'h0,     ST_RUN,    0, 0, 16'h0,    17'h0,     0);

    for (int i = 0; i < 18; i++) begin
      start = tbl[i].st; stop = tbl[i].sp; rate_we = tbl[i].we; rate = tbl[i].rt;
      ddc_val = tbl[i].dv; ready = tbl[i].rdy; amp = tbl[i].a; phase = tbl[i].p;
      tick();
      chk($sformatf("tbl%0d_state", i), 32'(dbg_state), 32'(tbl[i].es));
      chk($sformatf("tbl%0d_ddc_rst", i), 32'(ddc_rst), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_cfg_err", i), 32'(cfg_err), 32'(tbl[i].ec));
      chk($sformatf("tbl%0d_en", i), 32'(ddc_en), 32'(tbl[i].es != ST_IDLE));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_amp", i), 32'(out_amp), 32'(tbl[i].ea));
        chk($sformatf("tbl%0d_phase", i), 32'(out_phase), 32'(tbl[i].ep));
      end
    end
    idle_inputs();

    // rate 4 (the rate-0 write in IDLE was rejected): act_out every 4th act
    act_burst("r4", 40, 4);

    // backpressure: first sample held, second dropped, overflow sticky
    ready = 0; ddc_val = 1; amp = 16'h1111;
    exp_q.push_back(16'h1111);
    tick();
    chk("bp_valid1", 32'(out_valid), 32'd1);
    chk("bp_amp1", 32'(out_amp), 32'(exp_q[0]));
    chk("bp_ovf1", 32'(overflow), 32'd0);
    amp = 16'h2222;
    tick();
    chk("bp_valid2", 32'(out_valid), 32'd1);
    chk("bp_amp2", 32'(out_amp), 32'(exp_q[0]));
    chk("bp_ovf2", 32'(overflow), 32'd1);
    ddc_val = 0; ready = 1;
    tick();
    void'(exp_q.pop_front());
    chk("bp_drain", 32'(out_valid), 32'd0);
    chk("bp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("bp_ovf_sticky", 32'(overflow), 32'd1);

    // out-of-range rate writes in RUN
    rate_we = 1; rate = 7'd0;
    tick();
    rate_we = 0;
    chk("cfg0_err", 32'(cfg_err), 32'd1);
    chk("cfg0_state", 32'(dbg_state), 32'(ST_RUN));
    tick();
    chk("cfg0_pulse", 32'(cfg_err), 32'd0);
    rate_we = 1; rate = 7'd65;
    tick();
    rate_we = 0;
    chk("cfg65_err", 32'(cfg_err), 32'd1);
    chk("cfg65_state", 32'(dbg_state), 32'(ST_RUN));
    tick();
    chk("cfg65_pulse", 32'(cfg_err), 32'd0);
    act_burst("r4b", 8, 4);

    // valid rate 8 in RUN restarts through FLUSH
    rate_we = 1; rate = 7'd8;
    tick();
    rate_we = 0;
    chk("r8_flush", 32'(dbg_state), 32'(ST_FLUSH));
    chk("r8_cfg_err", 32'(cfg_err), 32'd0);
    chk("r8_ovf_kept", 32'(overflow), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("r8_ddc_rst", 32'(ddc_rst), 32'd1);
    end
    tick();
    chk("r8_settle", 32'(dbg_state), 32'(ST_SETTLE));
    act_burst("r8", 16, 8);
    settle_drop("r8");

    // stop wins over simultaneous start
    stop = 1; start = 1;
    tick();
    stop = 0; start = 0;
    chk("ss_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("ss_busy", 32'(busy | ddc_en), 32'd0);
    chk("ss_ovf_kept", 32'(overflow), 32'd1);
    start = 1;
    tick();
    start = 0;
    chk("restart_state", 32'(dbg_state), 32'(ST_FLUSH));
    chk("restart_ovf_clr", 32'(overflow), 32'd0);
    repeat (4) tick();
    settle_drop("rs");
    ready = 0; ddc_val = 1; amp = 16'h7777;
    tick();
    ddc_val = 0;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    adc_valid = 1;
    tick();
    chk("pre_rst_act", 32'(act), 32'd1);

    // asynchronous reset in the middle of a clock period
    #2 rst = 1;
    #1;
    chk("arst_outs", 32'({ddc_en, ddc_rst, act, act_out, out_valid, busy, overflow, cfg_err}), 32'd0);
    chk("arst_data", 32'({out_amp, out_phase}), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    rst = 0;
    ddc_val = 1; ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_quiet", 32'({act, act_out, out_valid, busy, ddc_rst}), 32'd0);
    end
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog: the directed run is far shorter than this
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
